// File: rtl/uart_line_adapter.sv
// Bridges DUT 8N1 UART pins to byte-wide ready/valid streams; RX bytes buffered in a FIFO.
// Latency: RX byte visible the cycle after the stop-bit sample; TX rxd start bit the cycle after handshake.
// Backpressure: serial_in_ready low while a frame is sent; full RX FIFO drops bytes and sets sticky overflow.
// Optional UART_ADAPTER_FRAME_ERR_EN adds a saturating frame_err_count output.
module uart_line_adapter #(
    parameter int DIV        = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       txd,
    output logic       rxd,
    output logic       serial_out_valid,
    input  logic       serial_out_ready,
    output logic [7:0] serial_out_bits,
    input  logic       serial_in_valid,
    output logic       serial_in_ready,
    input  logic [7:0] serial_in_bits,
    output logic       overflow
`ifdef UART_ADAPTER_FRAME_ERR_EN
    ,
    output logic [15:0] frame_err_count
`endif
);

    localparam int CW = $clog2(DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;

    // ---------------- RX synchroniser and edge detect ----------------
    logic sync1_q, sync2_q, prev_q;
    logic txd_s, fall_edge;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= txd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign txd_s     = sync2_q;
    assign fall_edge = prev_q && !txd_s;

    // ---------------- RX deserialiser ----------------
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic          rx_push, rx_ferr;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_sr_d    = rx_sr_q;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (fall_edge) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CNT_HALF;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (!txd_s) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = CNT_BIT;
                        rx_idx_d   = 3'd0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_sr_d  = {txd_s, rx_sr_q[7:1]};
                    rx_cnt_d = CNT_BIT;
                    if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RX_IDLE;
                    rx_push    = txd_s;
                    rx_ferr    = !txd_s;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sr_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sr_q    <= rx_sr_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          pop, full, push_ok, overflow_q;

    assign serial_out_valid = (count_q != '0);
    assign serial_out_bits  = fifo_mem[rd_ptr_q];
    assign pop              = serial_out_valid && serial_out_ready;
    assign full             = (count_q == CNT_FULL);
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign push_ok          = rx_push && (!full || pop);
    assign overflow         = overflow_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= rx_sr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (rx_push && !push_ok) overflow_q <= 1'b1;
        end
    end

`ifdef UART_ADAPTER_FRAME_ERR_EN
    logic [15:0] ferr_cnt_q;

    always_ff @(posedge clock) begin
        if (reset)                                  ferr_cnt_q <= '0;
        else if (rx_ferr && ferr_cnt_q != 16'hFFFF) ferr_cnt_q <= ferr_cnt_q + 16'd1;
    end

    assign frame_err_count = ferr_cnt_q;
`else
    logic unused_ferr;
    assign unused_ferr = rx_ferr;
`endif

    // ---------------- TX serialiser ----------------
    logic [0:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [8:0]    tx_sr_q, tx_sr_d;
    logic          rxd_q, rxd_d;
    logic          ready_q;

    assign serial_in_ready = ready_q;
    assign rxd             = rxd_q;

    // tx_sr holds {stop, data}; tx_bit 0 is the start bit, 9 the stop bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sr_d    = tx_sr_q;
        rxd_d      = rxd_q;
        if (tx_state_q == TX_IDLE) begin
            if (serial_in_valid && ready_q) begin
                tx_state_d = TX_SEND;
                tx_sr_d    = {1'b1, serial_in_bits};
                tx_cnt_d   = CNT_BIT;
                tx_bit_d   = 4'd0;
                rxd_d      = 1'b0;
            end
        end else if (tx_cnt_q == '0) begin
            tx_cnt_d = CNT_BIT;
            if (tx_bit_q == 4'd9) begin
                tx_state_d = TX_IDLE;
            end else begin
                rxd_d    = tx_sr_q[0];
                tx_sr_d  = {1'b1, tx_sr_q[8:1]};
                tx_bit_d = tx_bit_q + 4'd1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sr_q    <= '1;
            rxd_q      <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sr_q    <= tx_sr_d;
            rxd_q      <= rxd_d;
            ready_q    <= (tx_state_d == TX_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_line_adapter.sv
// Directed bench for uart_line_adapter (DIV=16, FIFO_DEPTH=8); frame_err_count checked when
// UART_ADAPTER_FRAME_ERR_EN is defined.
module tb_uart_line_adapter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       txd = 1'b1;
    logic       rxd;
    logic       serial_out_valid;
    logic       serial_out_ready = 1'b1;
    logic [7:0] serial_out_bits;
    logic       serial_in_valid = 1'b0;
    logic       serial_in_ready;
    logic [7:0] serial_in_bits = 8'h00;
    logic       overflow;
`ifdef UART_ADAPTER_FRAME_ERR_EN
    logic [15:0] frame_err_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_q[$];
    int vld_cycles = 0;

    uart_line_adapter #(.DIV(16), .FIFO_DEPTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .txd              (txd),
        .rxd              (rxd),
        .serial_out_valid (serial_out_valid),
        .serial_out_ready (serial_out_ready),
        .serial_out_bits  (serial_out_bits),
        .serial_in_valid  (serial_in_valid),
        .serial_in_ready  (serial_in_ready),
        .serial_in_bits   (serial_in_bits),
        .overflow         (overflow)
`ifdef UART_ADAPTER_FRAME_ERR_EN
        ,
        .frame_err_count  (frame_err_count)
`endif
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && serial_out_valid) vld_cycles++;
        if (!reset && serial_out_valid && serial_out_ready) rx_q.push_back(serial_out_bits);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            txd = f[i];
            idle(16);
        end
        txd = 1'b1;
    endtask

    task automatic do_tx(input logic [7:0] b);
        int n;
        int low;
        logic expb;
        n = 0;
        low = 0;
        while (!serial_in_ready && n < 500) begin
            idle(1);
            n++;
        end
        checks++;
        if (!serial_in_ready) begin
            errors++;
            $display("FAIL tx_ready_wait: serial_in_ready=%0b required 1", serial_in_ready);
            return;
        end
        serial_in_bits  = b;
        serial_in_valid = 1'b1;
        @(posedge clock);
        #1;
        serial_in_valid = 1'b0;
        serial_in_bits  = ~b;
        for (int i = 0; i < 160; i++) begin
            @(negedge clock);
            if (!serial_in_ready) low++;
            if (i % 16 == 8) begin
                if (i / 16 == 0)      expb = 1'b0;
                else if (i / 16 == 9) expb = 1'b1;
                else                  expb = b[i/16 - 1];
                checks++;
                if (rxd !== expb) begin
                    errors++;
                    $display("FAIL tx_bit%0d byte %02h: rxd=%0b required %0b", i / 16, b, rxd, expb);
                end
            end
        end
        @(negedge clock);
        checks++;
        if (low !== 160) begin
            errors++;
            $display("FAIL tx_ready_low: %0d cycles required 160", low);
        end
        checks++;
        if (serial_in_ready !== 1'b1 || rxd !== 1'b1) begin
            errors++;
            $display("FAIL tx_end: ready=%0b rxd=%0b required 1 1", serial_in_ready, rxd);
        end
        idle(1);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (rxd !== 1'b1 || serial_out_valid !== 1'b0 || serial_in_ready !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rxd=%0b vld=%0b rdy=%0b ovf=%0b required 1 0 0 0",
                     rxd, serial_out_valid, serial_in_ready, overflow);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (serial_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: %0b required 1", serial_in_ready);
        end
        idle(1);
    endtask

    task automatic test_rx_byte;
        rx_q.delete();
        vld_cycles = 0;
        serial_out_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        idle(8);
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h55) begin
            errors++;
            $display("FAIL rx_55: count=%0d first=%02h required 1 55", rx_q.size(),
                     rx_q.size() > 0 ? rx_q[0] : 8'hxx);
        end
        checks++;
        if (vld_cycles !== 1) begin
            errors++;
            $display("FAIL rx_55_valid_len: %0d cycles required 1", vld_cycles);
        end
    endtask

    task automatic test_tx_byte;
        do_tx(8'hA3);
    endtask

    task automatic test_overflow;
        rx_q.delete();
        serial_out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
        idle(20);
        checks++;
        if (overflow !== 1'b1 || serial_out_valid !== 1'b1 || serial_out_bits !== 8'h00) begin
            errors++;
            $display("FAIL ovf_state: ovf=%0b vld=%0b head=%02h required 1 1 00",
                     overflow, serial_out_valid, serial_out_bits);
        end
        serial_out_ready = 1'b1;
        idle(12);
        checks++;
        if (rx_q.size() !== 8) begin
            errors++;
            $display("FAIL ovf_drain_count: %0d required 8", rx_q.size());
        end
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain_%0d: %02h required %02h", i, rx_q[i], 8'(i));
            end
        end
        @(negedge clock);
        checks++;
        if (serial_out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after_drain: vld=%0b ovf=%0b required 0 1", serial_out_valid, overflow);
        end
        idle(1);
    endtask

    task automatic test_glitch;
        rx_q.delete();
        txd = 1'b0;
        idle(4);
        txd = 1'b1;
        idle(40);
        checks++;
        if (rx_q.size() !== 0) begin
            errors++;
            $display("FAIL glitch_no_byte: count=%0d required 0", rx_q.size());
        end
        send_frame(8'h3C, 1'b1);
        idle(8);
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h3C) begin
            errors++;
            $display("FAIL glitch_next_3c: count=%0d first=%02h required 1 3c", rx_q.size(),
                     rx_q.size() > 0 ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_frame_err;
        rx_q.delete();
        send_frame(8'h7E, 1'b0);
        idle(20);
        checks++;
        if (rx_q.size() !== 0) begin
            errors++;
            $display("FAIL ferr_no_byte: count=%0d required 0", rx_q.size());
        end
`ifdef UART_ADAPTER_FRAME_ERR_EN
        checks++;
        if (frame_err_count !== 16'd1) begin
            errors++;
            $display("FAIL ferr_count: %0d required 1", frame_err_count);
        end
`endif
        send_frame(8'h81, 1'b1);
        idle(8);
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h81) begin
            errors++;
            $display("FAIL ferr_next_81: count=%0d first=%02h required 1 81", rx_q.size(),
                     rx_q.size() > 0 ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        rx_q.delete();
        n = 0;
        while (!serial_in_ready && n < 500) begin
            idle(1);
            n++;
        end
        serial_in_bits  = 8'h99;
        serial_in_valid = 1'b1;
        @(posedge clock);
        #1;
        serial_in_valid = 1'b0;
        txd = 1'b0;
        idle(16);
        txd = 1'b1;
        idle(16);
        txd = 1'b0;
        idle(20);
        reset = 1'b1;
        txd = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (rxd !== 1'b1 || serial_out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rxd=%0b vld=%0b ovf=%0b required 1 0 0", rxd, serial_out_valid, overflow);
        end
        idle(2);
        reset = 1'b0;
        idle(40);
        checks++;
        if (rx_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_byte: count=%0d required 0", rx_q.size());
        end
        fork
            send_frame(8'h42, 1'b1);
            do_tx(8'h42);
        join
        idle(8);
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h42) begin
            errors++;
            $display("FAIL mid_reset_rx_42: count=%0d first=%02h required 1 42", rx_q.size(),
                     rx_q.size() > 0 ? rx_q[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_rx_byte();
        test_tx_byte();
        test_overflow();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
